mem_ctrl: RTL

Memory-side responder for the MEM stage's RAM request interface. It accepts word/half/byte store requests and word read requests from MEM, and instruction fetch requests from IF. It serialises each request onto the single byte-wide synchronous RAM port, then returns a one-cycle done pulse together with the assembled little-endian data. It sits between the core pipeline and the external byte RAM, and is the only master of that RAM.

---
 rtl/mem_ctrl_pkg.sv | 65 ++++++
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM/IF RAM responder: FSM states, request
// sources, pipeline constants and store-width pointer encodings.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_MEM = 1'b0,
    SRC_IF  = 1'b1
  } src_e;

  localparam logic        TRUE         = 1'b1;
  localparam logic        FALSE        = 1'b0;
  localparam logic [31:0] ZERO         = 32'h0000_0000;
  localparam logic        WRITE_ENABLE = 1'b1;

  // Store pointer values: bytes written = 4 - pointer
  localparam logic [3:0] PTR_SB = 4'd3;
  localparam logic [3:0] PTR_SH = 4'd2;
  localparam logic [3:0] PTR_SW = 4'd0;

  // Number of bytes a store moves; unknown pointer values fall back to a word.
  function automatic logic [2:0] byte_count(input logic [3:0] ptr);
    logic [2:0] n;
    case (ptr)
      PTR_SB:  n = 3'd1;
      PTR_SH:  n = 3'd2;
      PTR_SW:  n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Little-endian byte extraction from a 32-bit word.
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Little-endian byte insertion into a 32-bit word.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-master responder for the byte-wide synchronous RAM. Serialises MEM
// stores/loads and IF fetches one byte per cycle and returns a one-cycle done
// pulse with the little-endian assembled word. All outputs are registered.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_r_req_i,
  input  logic              ram_w_req_i,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [31:0]       ram_w_data_i,
  input  logic [3:0]        buffer_pointer_i,
  output logic              ram_done_o,
  output logic [31:0]       ram_r_data_o,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_inst_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  // Byte k requested in cycle k is on mem_din in cycle k+LAT; last capture at 3+LAT.
  localparam logic [2:0] LAT_C      = 3'(RAM_RD_LAT);
  localparam logic [2:0] LAST_CAP_C = 3'(RAM_RD_LAT + 3);

  state_e            state_q, state_d;
  src_e              src_q, src_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        len_q, len_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              ram_done_q, ram_done_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       ram_r_data_q, ram_r_data_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [2:0]        cnt_nx_s;
  logic [31:0]       word_s;

  // Arbitration, byte sequencing and next values of all registered outputs.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    mem_a_d      = '0;
    mem_wr_d     = FALSE;
    mem_dout_d   = 8'h00;
    ram_done_d   = FALSE;
    if_done_d    = FALSE;
    ram_r_data_d = ZERO;
    if_inst_d    = ZERO;
    cnt_nx_s     = cnt_q + 3'd1;
    word_s       = buf_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        buf_d = ZERO;
        if (ram_w_req_i) begin
          state_d    = ST_WRITE;
          src_d      = SRC_MEM;
          base_d     = ram_addr_i;
          wdata_d    = ram_w_data_i;
          len_d      = byte_count(buffer_pointer_i);
          mem_a_d    = ram_addr_i;
          mem_dout_d = ram_w_data_i[7:0];
          mem_wr_d   = WRITE_ENABLE;
        end else if (ram_r_req_i) begin
          state_d = ST_READ;
          src_d   = SRC_MEM;
          base_d  = ram_addr_i;
          len_d   = 3'd4;
          mem_a_d = ram_addr_i;
        end else if (if_req_i) begin
          state_d = ST_READ;
          src_d   = SRC_IF;
          base_d  = if_addr_i;
          len_d   = 3'd4;
          mem_a_d = if_addr_i;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        cnt_d = cnt_nx_s;
        if (cnt_nx_s < 3'd4) begin
          mem_a_d = base_q + ADDR_W'(cnt_nx_s);
        end else begin
          mem_a_d = '0;
        end
        if (cnt_q >= LAT_C) begin
          word_s = put_byte(buf_q, 2'(cnt_q - LAT_C), mem_din);
          buf_d  = word_s;
        end else begin
          buf_d = buf_q;
        end
        if (cnt_q == LAST_CAP_C) begin
          state_d = ST_RESP;
          if (src_q == SRC_IF) begin
            if_done_d = TRUE;
            if_inst_d = word_s;
          end else begin
            ram_done_d   = TRUE;
            ram_r_data_d = word_s;
          end
        end else begin
          state_d = ST_READ;
        end
      end

      ST_WRITE: begin
        if (cnt_nx_s < len_q) begin
          cnt_d      = cnt_nx_s;
          mem_a_d    = base_q + ADDR_W'(cnt_nx_s);
          mem_dout_d = get_byte(wdata_q, 2'(cnt_nx_s));
          mem_wr_d   = WRITE_ENABLE;
        end else begin
          state_d      = ST_RESP;
          ram_done_d   = TRUE;
          ram_r_data_d = ZERO;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, transaction context and output registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_MEM;
      base_q       <= '0;
      wdata_q      <= ZERO;
      len_q        <= 3'd0;
      cnt_q        <= 3'd0;
      buf_q        <= ZERO;
      mem_a_q      <= '0;
      mem_wr_q     <= FALSE;
      mem_dout_q   <= 8'h00;
      ram_done_q   <= FALSE;
      if_done_q    <= FALSE;
      ram_r_data_q <= ZERO;
      if_inst_q    <= ZERO;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_wr_q     <= mem_wr_d;
      mem_dout_q   <= mem_dout_d;
      ram_done_q   <= ram_done_d;
      if_done_q    <= if_done_d;
      ram_r_data_q <= ram_r_data_d;
      if_inst_q    <= if_inst_d;
    end
  end

  assign mem_a        = mem_a_q;
  assign mem_wr       = mem_wr_q;
  assign mem_dout     = mem_dout_q;
  assign ram_done_o   = ram_done_q;
  assign if_done_o    = if_done_q;
  assign ram_r_data_o = ram_r_data_q;
  assign if_inst_o    = if_inst_q;

endmodule
